// File: rtl/sram64kb_ctrl.sv
// Single-outstanding byte controller for a 64-bank x 1024x8 SRAM array.
// Requests are split into bank/row, strobed with one cycle of setup, and answered on a valid/ready port.
module sram64kb_ctrl #(
    parameter int READ_WAIT = 1,
    parameter bit WRITE_RSP = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [7:0]  RSP_RDATA,
    output logic        RSP_WRITE,
    output logic [9:0]  MEM_ADDR,
    output logic        MEM_CE,
    output logic        MEM_WEB,
    output logic [63:0] MEM_OEB,
    output logic [63:0] MEM_CSB,
    output logic [7:0]  MEM_IDATA,
    output logic [5:0]  MEM_ODATA_SELECT,
    input  logic [7:0]  MEM_ODATA,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_write_q, rsp_write_d;
    logic [9:0]  mem_addr_q, mem_addr_d;
    logic        mem_ce_q, mem_ce_d;
    logic        mem_web_q, mem_web_d;
    logic [63:0] mem_oeb_q, mem_oeb_d;
    logic [63:0] mem_csb_q, mem_csb_d;
    logic [7:0]  mem_idata_q, mem_idata_d;
    logic [5:0]  mem_sel_q, mem_sel_d;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;
        mem_addr_d  = mem_addr_q;
        mem_web_d   = mem_web_q;
        mem_oeb_d   = mem_oeb_q;
        mem_csb_d   = mem_csb_q;
        mem_idata_d = mem_idata_q;
        mem_sel_d   = mem_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && req_ready_q) begin
                    write_d     = REQ_WRITE;
                    rsp_write_d = REQ_WRITE;
                    rsp_rdata_d = 8'h00;
                    mem_addr_d  = REQ_ADDR[9:0];
                    mem_sel_d   = REQ_ADDR[15:10];
                    mem_csb_d   = ~(64'd1 << REQ_ADDR[15:10]);
                    mem_idata_d = REQ_WDATA;
                    mem_web_d   = ~REQ_WRITE;
                    mem_oeb_d   = REQ_WRITE ? '1 : ~(64'd1 << REQ_ADDR[15:10]);
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                if (write_q) begin
                    // The write completes on the CE rising edge, so release the selects right away.
                    mem_web_d = 1'b1;
                    mem_csb_d = '1;
                    mem_oeb_d = '1;
                    state_d   = WRITE_RSP ? ST_RESP : ST_IDLE;
                end else begin
                    cnt_d   = 4'(READ_WAIT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                rsp_rdata_d = MEM_ODATA;
                mem_csb_d   = '1;
                mem_oeb_d   = '1;
                mem_web_d   = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake and strobe outputs follow the state being entered, keeping them registered.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        mem_ce_d    = (state_d == ST_STROBE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_write_q <= 1'b0;
            mem_addr_q  <= 10'd0;
            mem_ce_q    <= 1'b0;
            mem_web_q   <= 1'b1;
            mem_oeb_q   <= '1;
            mem_csb_q   <= '1;
            mem_idata_q <= 8'h00;
            mem_sel_q   <= 6'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_ce_q    <= mem_ce_d;
            mem_web_q   <= mem_web_d;
            mem_oeb_q   <= mem_oeb_d;
            mem_csb_q   <= mem_csb_d;
            mem_idata_q <= mem_idata_d;
            mem_sel_q   <= mem_sel_d;
        end
    end

    assign REQ_READY        = req_ready_q;
    assign RSP_VALID        = rsp_valid_q;
    assign RSP_RDATA        = rsp_rdata_q;
    assign RSP_WRITE        = rsp_write_q;
    assign MEM_ADDR         = mem_addr_q;
    assign MEM_CE           = mem_ce_q;
    assign MEM_WEB          = mem_web_q;
    assign MEM_OEB          = mem_oeb_q;
    assign MEM_CSB          = mem_csb_q;
    assign MEM_IDATA        = mem_idata_q;
    assign MEM_ODATA_SELECT = mem_sel_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sram64kb_ctrl.sv
// Bench for sram64kb_ctrl: pin-level SRAM array model, byte-array reference model and response scoreboard.
// Handshake rule: a transfer happens on a rising CLK edge where both valid and ready are 1; valid holds until then.
module tb_sram64kb_ctrl;

    localparam int READ_WAIT = 3;
    localparam bit WRITE_RSP = 1'b1;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd5;

    logic        CLK, RSTN;
    logic        REQ_VALID, REQ_READY, REQ_WRITE;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic        RSP_VALID, RSP_READY, RSP_WRITE;
    logic [7:0]  RSP_RDATA;
    logic [9:0]  MEM_ADDR;
    logic        MEM_CE, MEM_WEB;
    logic [63:0] MEM_OEB, MEM_CSB;
    logic [7:0]  MEM_IDATA, MEM_ODATA;
    logic [5:0]  MEM_ODATA_SELECT;
    logic [2:0]  dbg_state;

    sram64kb_ctrl #(.READ_WAIT(READ_WAIT), .WRITE_RSP(WRITE_RSP)) u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_WRITE(RSP_WRITE),
        .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB),
        .MEM_CSB(MEM_CSB), .MEM_IDATA(MEM_IDATA), .MEM_ODATA_SELECT(MEM_ODATA_SELECT),
        .MEM_ODATA(MEM_ODATA), .dbg_state_o(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    int         rsp_mode = 0;
    int         ce_pulses = 0;
    logic [7:0] ref_mem [0:65535];
    logic [7:0] sram_arr [0:65535];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Array model: acts on the CE rising edge using the one-hot CSB, returns the OEB-gated byte.
    int         sm_nb;
    logic [5:0] sm_bk, dout_bank;
    logic [7:0] dout;
    logic       dout_ok = 1'b0;
    always @(posedge MEM_CE) begin
        ce_pulses++;
        sm_nb = 0;
        sm_bk = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (!MEM_CSB[i]) begin
                sm_nb++;
                sm_bk = 6'(i);
            end
        end
        if (sm_nb == 1) begin
            if (!MEM_WEB) begin
                sram_arr[{sm_bk, MEM_ADDR}] = MEM_IDATA;
            end else begin
                dout      = sram_arr[{sm_bk, MEM_ADDR}];
                dout_bank = sm_bk;
                dout_ok   = 1'b1;
            end
        end
    end
    assign MEM_ODATA = (dout_ok && dout_bank == MEM_ODATA_SELECT && !MEM_OEB[MEM_ODATA_SELECT]) ? dout : 8'h00;

    // Response monitor: chooses RSP_READY for the coming edge, then pops on a completing handshake.
    logic       prev_valid = 1'b0, prev_hs = 1'b0, prev_write = 1'b0;
    logic [7:0] prev_rdata = 8'h00;
    logic [8:0] e;
    always @(negedge CLK) begin
        case (rsp_mode)
            0: RSP_READY = 1'b1;
            1: RSP_READY = ($urandom_range(0, 3) != 0);
            default: RSP_READY = 1'b0;
        endcase
        if (prev_valid && !prev_hs && RSTN) begin
            check("rsp_valid_hold", RSP_VALID, 1'b1);
            check("rsp_rdata_hold", RSP_RDATA, prev_rdata);
            check("rsp_write_hold", RSP_WRITE, prev_write);
        end
        if (RSP_VALID && RSP_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_write", RSP_WRITE, e[8]);
                check("rsp_rdata", RSP_RDATA, e[7:0]);
            end
        end
        prev_valid = RSP_VALID && RSTN;
        prev_hs    = RSP_VALID && RSP_READY;
        prev_rdata = RSP_RDATA;
        prev_write = RSP_WRITE;
    end

    // Array-side invariants, sampled every cycle.
    logic [9:0]  snap_addr;
    logic [63:0] snap_csb;
    logic        snap_web;
    always @(negedge CLK) begin
        check("csb_onehot", ($countones(~MEM_CSB) <= 1), 1'b1);
        check("oeb_implies_csb_read", ((~MEM_OEB & MEM_CSB) == 64'd0) && (&MEM_OEB || MEM_WEB), 1'b1);
        if (MEM_CE) check("ce_only_in_strobe", dbg_state, ST_STROBE);
        if (dbg_state == ST_SETUP) begin
            snap_addr = MEM_ADDR;
            snap_csb  = MEM_CSB;
            snap_web  = MEM_WEB;
        end else if (dbg_state == ST_STROBE || dbg_state == ST_WAIT) begin
            check("hold_addr", MEM_ADDR, snap_addr);
            check("hold_csb", MEM_CSB, snap_csb);
            check("hold_web", MEM_WEB, snap_web);
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
        int t = 0;
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WRITE = w;
        REQ_ADDR  = a;
        REQ_WDATA = d;
        while (!REQ_READY && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (!REQ_READY) begin
            check("req_accept_timeout", 1'b1, 1'b0);
            REQ_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        if (w) begin
            ref_mem[a] = d;
            if (WRITE_RSP) exp_q.push_back({1'b1, 8'h00});
        end else begin
            exp_q.push_back({1'b0, ref_mem[a]});
        end
        #1 REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || !REQ_READY) && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 500) check("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic check_reset_vals(input logic rdy);
        check("rst_req_ready", REQ_READY, rdy);
        check("rst_rsp_valid", RSP_VALID, 1'b0);
        check("rst_rsp_rdata", RSP_RDATA, 8'h00);
        check("rst_rsp_write", RSP_WRITE, 1'b0);
        check("rst_mem_addr", MEM_ADDR, 10'd0);
        check("rst_mem_ce", MEM_CE, 1'b0);
        check("rst_mem_web", MEM_WEB, 1'b1);
        check("rst_mem_oeb", MEM_OEB, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_mem_csb", MEM_CSB, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_mem_idata", MEM_IDATA, 8'h00);
        check("rst_odata_sel", MEM_ODATA_SELECT, 6'd0);
    endtask

    logic [15:0] pool [0:15];
    logic [15:0] rd_addr [0:2];
    logic [5:0]  rd_bank [0:2];
    logic [7:0]  v;
    int          n, ce0;
    logic        w;
    logic [15:0] a;

    initial begin
        RSTN = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = 16'h0; REQ_WDATA = 8'h0; RSP_READY = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            sram_arr[i] = v;
            ref_mem[i]  = v;
        end
        repeat (3) @(negedge CLK);
        check_reset_vals(1'b0);
        RSTN = 1'b1;
        @(negedge CLK);
        check_reset_vals(1'b1);

        // Write then read bank 0 row 0, with strobe count and latency.
        ce0 = ce_pulses;
        issue(1'b1, 16'h0000, 8'hA5);
        @(negedge CLK);
        check("wr_csb", MEM_CSB, ~64'd1);
        check("wr_web", MEM_WEB, 1'b0);
        check("wr_oeb", MEM_OEB, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wr_idata", MEM_IDATA, 8'hA5);
        wait_idle();
        check("wr_ce_pulses", ce_pulses - ce0, 1);
        issue(1'b0, 16'h0000, 8'h00);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) check("rd_oeb", MEM_OEB, ~64'd1);
        end while (!RSP_VALID && n < 40);
        check("rd_latency", n, 4 + READ_WAIT);
        check("rd_data_a5", RSP_RDATA, 8'hA5);
        wait_idle();
        issue(1'b1, 16'h1234, 8'h55);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!RSP_VALID && n < 40);
        check("wr_latency", n, 3);
        wait_idle();

        // Address boundaries in banks 63 and 0.
        rd_addr[0] = 16'hFFFF; rd_addr[1] = 16'hFC00; rd_addr[2] = 16'h03FF;
        rd_bank[0] = 6'd63;    rd_bank[1] = 6'd63;    rd_bank[2] = 6'd0;
        issue(1'b1, 16'hFFFF, 8'h3C);
        issue(1'b1, 16'hFC00, 8'h11);
        issue(1'b1, 16'h03FF, 8'h77);
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, rd_addr[k], 8'h00);
            @(negedge CLK);
            check("bnd_sel", MEM_ODATA_SELECT, rd_bank[k]);
            check("bnd_csb", MEM_CSB, ~(64'd1 << rd_bank[k]));
            check("bnd_row", MEM_ADDR, rd_addr[k][9:0]);
        end
        wait_idle();

        // Response backpressure with a competing request held at the input.
        rsp_mode = 2;
        issue(1'b0, 16'hFFFF, 8'h00);
        n = 0;
        while (!RSP_VALID && n < 40) begin
            @(negedge CLK);
            n++;
        end
        fork
            issue(1'b1, 16'h0800, 8'h99);
            begin
                repeat (10) begin
                    @(negedge CLK);
                    check("bp_req_ready", REQ_READY, 1'b0);
                    check("bp_state", dbg_state, ST_RESP);
                    check("bp_rdata", RSP_RDATA, 8'h3C);
                end
                rsp_mode = 0;
            end
        join
        wait_idle();

        // Reset during the WAIT phase of a read.
        issue(1'b0, 16'h0400, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("rst_in_wait_state", dbg_state, ST_WAIT);
        RSTN = 1'b0;
        @(negedge CLK);
        check_reset_vals(1'b0);
        exp_q.delete();
        RSTN = 1'b1;
        @(negedge CLK);
        check_reset_vals(1'b1);

        // Random traffic with backpressure.
        for (int i = 0; i < 16; i++) pool[i] = 16'($urandom);
        pool[0] = 16'h0000;
        pool[1] = 16'hFFFF;
        rsp_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 15)];
            issue(w, a, 8'($urandom));
        end
        wait_idle();
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
